// File: rtl/pcu_pkg.sv
// Shared constants, state encoding and address helpers for the program counter unit.
// Word index is the byte address with the in-word offset bits dropped.
package pcu_pkg;

   localparam int ADDR_W      = 72;
   localparam int INSTR_BYTES = 8;
   localparam int MEM_WORDS   = 1024;
   localparam int OFFSET_W    = $clog2(INSTR_BYTES);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } pcu_state_t;

   function automatic logic [ADDR_W-OFFSET_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1:OFFSET_W];
   endfunction

endpackage

// File: rtl/pc_bound_check.sv
// Flags a byte address that is not instruction aligned or lies past the end of fetch memory.
// Shared by the redirect-target, current-pc and next-pc checks.
module pc_bound_check #(
   parameter int ADDR_W      = pcu_pkg::ADDR_W,
   parameter int INSTR_BYTES = pcu_pkg::INSTR_BYTES,
   parameter int MEM_WORDS   = pcu_pkg::MEM_WORDS
) (
   input  logic [ADDR_W-1:0] addr,
   output logic              illegal
);

   localparam int OFFSET_W = $clog2(INSTR_BYTES);
   localparam int IDX_W    = ADDR_W - OFFSET_W;
   localparam logic [IDX_W-1:0] WORD_LIMIT = IDX_W'(MEM_WORDS);

   logic misaligned;
   logic out_of_range;

   assign misaligned   = |addr[OFFSET_W-1:0];
   assign out_of_range = addr[ADDR_W-1:OFFSET_W] >= WORD_LIMIT;
   assign illegal      = misaligned | out_of_range;

endmodule

// File: rtl/program_counter_unit.sv
// Program counter and fetch sequencer: drives the fetch address and tracks which
// returned word is live, handling stalls, redirects, halt and address faults.
module program_counter_unit #(
   parameter int                ADDR_W      = pcu_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int                INSTR_BYTES = pcu_pkg::INSTR_BYTES,
   parameter int                MEM_WORDS   = pcu_pkg::MEM_WORDS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   input  logic              halt_req,
   output logic [ADDR_W-1:0] address,
   output logic [ADDR_W-1:0] fetch_pc,
   output logic              instr_valid,
   output logic              halted,
   output logic              fault
);

   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(INSTR_BYTES);
   localparam int CHK_TARGET = 0;
   localparam int CHK_PC     = 1;
   localparam int CHK_NEXT   = 2;

   pcu_pkg::pcu_state_t state_reg, state_next;
   logic [ADDR_W-1:0]   pc_reg, pc_next;
   logic [ADDR_W-1:0]   fetch_pc_reg, fetch_pc_next;
   logic                instr_valid_reg, instr_valid_next;
   logic                fault_reg, fault_next;
   logic                last_reg, last_next;

   logic [ADDR_W-1:0]   pc_plus;
   logic [ADDR_W-1:0]   target_plus;
   logic [ADDR_W-1:0]   chk_addr [3];
   logic [2:0]          chk_illegal;

   assign pc_plus     = pc_reg + STRIDE;
   assign target_plus = redirect_target + STRIDE;

   assign chk_addr[CHK_TARGET] = redirect_target;
   assign chk_addr[CHK_PC]     = pc_reg;
   assign chk_addr[CHK_NEXT]   = pc_plus;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_bound
         pc_bound_check #(
            .ADDR_W      (ADDR_W),
            .INSTR_BYTES (INSTR_BYTES),
            .MEM_WORDS   (MEM_WORDS)
         ) u_check (
            .addr    (chk_addr[gi]),
            .illegal (chk_illegal[gi])
         );
      end
   endgenerate

   // Redirect target goes straight to fetch; a stalled live word is re-read so fetch's output holds.
   always_comb begin
      address = pc_reg;
      if (state_reg == pcu_pkg::RUN) begin
         if (redirect_valid) begin
            address = redirect_target;
         end else if (stall && instr_valid_reg) begin
            address = fetch_pc_reg;
         end
      end
   end

   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      fetch_pc_next    = fetch_pc_reg;
      instr_valid_next = instr_valid_reg;
      fault_next       = fault_reg;
      last_next        = last_reg;

      if (state_reg == pcu_pkg::RUN) begin
         if (redirect_valid) begin
            last_next = 1'b0;
            if (chk_illegal[CHK_TARGET]) begin
               fault_next       = 1'b1;
               state_next       = pcu_pkg::HALT;
               instr_valid_next = 1'b0;
            end else begin
               pc_next          = target_plus;
               fetch_pc_next    = redirect_target;
               instr_valid_next = 1'b1;
            end
         end else if (halt_req) begin
            state_next       = pcu_pkg::HALT;
            instr_valid_next = 1'b0;
         end else if (stall && instr_valid_reg) begin
            // hold everything so decode sees the same word again
         end else if (last_reg || chk_illegal[CHK_PC]) begin
            // Last word has been consumed (or pc already sits past memory): nothing left to fetch.
            fault_next       = 1'b1;
            state_next       = pcu_pkg::HALT;
            instr_valid_next = 1'b0;
         end else begin
            fetch_pc_next    = pc_reg;
            instr_valid_next = 1'b1;
            if (chk_illegal[CHK_NEXT]) begin
               last_next = 1'b1;
            end else begin
               pc_next = pc_plus;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= pcu_pkg::RUN;
         pc_reg          <= RESET_PC;
         fetch_pc_reg    <= RESET_PC;
         instr_valid_reg <= 1'b0;
         fault_reg       <= 1'b0;
         last_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         fetch_pc_reg    <= fetch_pc_next;
         instr_valid_reg <= instr_valid_next;
         fault_reg       <= fault_next;
         last_reg        <= last_next;
      end
   end

   assign fetch_pc    = fetch_pc_reg;
   assign instr_valid = instr_valid_reg;
   assign halted      = (state_reg == pcu_pkg::HALT);
   assign fault       = fault_reg;

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit: hand-computed expectations checked with
// immediate assertions after each step.
module tb_program_counter_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [71:0] redirect_target;
   logic        halt_req;
   logic [71:0] address;
   logic [71:0] fetch_pc;
   logic        instr_valid;
   logic        halted;
   logic        fault;

   int checks   = 0;
   int failures = 0;

   program_counter_unit dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .halt_req        (halt_req),
      .address         (address),
      .fetch_pc        (fetch_pc),
      .instr_valid     (instr_valid),
      .halted          (halted),
      .fault           (fault)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic rv, input logic [71:0] rt, input logic hr);
      stall           = st;
      redirect_valid  = rv;
      redirect_target = rt;
      halt_req        = hr;
      #1;
   endtask

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 72'h0, 0);
      step();
      step();
      chk("rst_fetch_pc", fetch_pc, 72'h0);
      chk("rst_valid", {71'h0, instr_valid}, 72'h0);
      chk("rst_halted", {71'h0, halted}, 72'h0);
      chk("rst_fault", {71'h0, fault}, 72'h0);
      chk("rst_address", address, 72'h0);

      // free run
      reset = 1'b0;
      drive(0, 0, 72'h0, 0);
      chk("run0_addr", address, 72'd0);
      chk("run0_valid", {71'h0, instr_valid}, 72'h0);
      chk("run0_fpc", fetch_pc, 72'd0);
      step();
      chk("run1_addr", address, 72'd8);
      chk("run1_valid", {71'h0, instr_valid}, 72'h1);
      chk("run1_fpc", fetch_pc, 72'd0);
      step();
      chk("run2_addr", address, 72'd16);
      chk("run2_valid", {71'h0, instr_valid}, 72'h1);
      chk("run2_fpc", fetch_pc, 72'd8);
      step();
      chk("run3_addr", address, 72'd24);
      chk("run3_valid", {71'h0, instr_valid}, 72'h1);
      chk("run3_fpc", fetch_pc, 72'd16);

      // stall for three cycles at fetch_pc=16
      drive(1, 0, 72'h0, 0);
      for (int i = 0; i < 3; i++) begin
         chk("stall_addr", address, 72'd16);
         chk("stall_fpc", fetch_pc, 72'd16);
         chk("stall_valid", {71'h0, instr_valid}, 72'h1);
         step();
      end
      drive(0, 0, 72'h0, 0);
      chk("unstall_addr", address, 72'd24);
      chk("unstall_fpc", fetch_pc, 72'd16);
      step();
      chk("after_unstall_fpc", fetch_pc, 72'd24);
      chk("after_unstall_addr", address, 72'd32);

      // redirect while stalled at fetch_pc=8
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive(0, 0, 72'h0, 0);
      step();
      step();
      chk("pre_redir_fpc", fetch_pc, 72'd8);
      drive(1, 1, 72'h200, 0);
      chk("redir_addr", address, 72'h200);
      step();
      drive(0, 0, 72'h0, 0);
      chk("redir_fpc", fetch_pc, 72'h200);
      chk("redir_valid", {71'h0, instr_valid}, 72'h1);
      chk("redir_pc", address, 72'h208);
      step();
      chk("redir_next_fpc", fetch_pc, 72'h208);
      chk("redir_next_addr", address, 72'h210);

      // reach pc=40, then redirect and halt_req together
      drive(0, 1, 72'd32, 0);
      step();
      drive(0, 0, 72'h0, 0);
      chk("pc40_addr", address, 72'd40);
      drive(0, 1, 72'h100, 1);
      chk("rh_addr", address, 72'h100);
      step();
      drive(0, 0, 72'h0, 1);
      chk("rh_halted", {71'h0, halted}, 72'h0);
      chk("rh_fpc", fetch_pc, 72'h100);
      chk("rh_valid", {71'h0, instr_valid}, 72'h1);
      chk("rh_addr2", address, 72'h108);
      step();
      drive(0, 1, 72'h300, 0);
      chk("halt_halted", {71'h0, halted}, 72'h1);
      chk("halt_valid", {71'h0, instr_valid}, 72'h0);
      chk("halt_addr", address, 72'h108);
      chk("halt_fault", {71'h0, fault}, 72'h0);
      step();
      chk("halt_hold_halted", {71'h0, halted}, 72'h1);
      chk("halt_hold_valid", {71'h0, instr_valid}, 72'h0);
      chk("halt_hold_fpc", fetch_pc, 72'h100);
      chk("halt_hold_addr", address, 72'h108);

      // reset wins over a concurrent redirect, then misaligned redirect
      reset = 1'b1;
      drive(0, 1, 72'h200, 0);
      step();
      reset = 1'b0;
      drive(0, 0, 72'h0, 0);
      chk("rstwin_addr", address, 72'd0);
      chk("rstwin_valid", {71'h0, instr_valid}, 72'h0);
      chk("rstwin_halted", {71'h0, halted}, 72'h0);
      step();
      chk("rstwin_valid1", {71'h0, instr_valid}, 72'h1);
      chk("rstwin_fpc1", fetch_pc, 72'd0);
      drive(0, 1, 72'h203, 0);
      chk("mis_addr", address, 72'h203);
      step();
      drive(0, 0, 72'h0, 0);
      chk("mis_fault", {71'h0, fault}, 72'h1);
      chk("mis_halted", {71'h0, halted}, 72'h1);
      chk("mis_valid", {71'h0, instr_valid}, 72'h0);
      chk("mis_addr_frozen", address, 72'd8);
      step();
      step();
      chk("mis_addr_frozen2", address, 72'd8);
      chk("mis_fault_sticky", {71'h0, fault}, 72'h1);
      reset = 1'b1;
      step();
      chk("mis_rst_fault", {71'h0, fault}, 72'h0);
      chk("mis_rst_halted", {71'h0, halted}, 72'h0);

      // redirect past the end of memory
      reset = 1'b0;
      drive(0, 1, 72'h2000, 0);
      chk("oob_addr", address, 72'h2000);
      step();
      drive(0, 0, 72'h0, 0);
      chk("oob_fault", {71'h0, fault}, 72'h1);
      chk("oob_halted", {71'h0, halted}, 72'h1);
      chk("oob_addr_frozen", address, 72'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive(0, 0, 72'h0, 0);

      // run off the last word of memory
      drive(0, 1, 72'd8176, 0);
      step();
      drive(0, 0, 72'h0, 0);
      chk("end_fpc1022", fetch_pc, 72'd8176);
      chk("end_addr1023", address, 72'd8184);
      step();
      chk("end_fpc1023", fetch_pc, 72'd8184);
      chk("end_valid1023", {71'h0, instr_valid}, 72'h1);
      chk("end_fault_pre", {71'h0, fault}, 72'h0);
      chk("end_halted_pre", {71'h0, halted}, 72'h0);
      chk("end_addr_hold", address, 72'd8184);
      step();
      chk("end_fault", {71'h0, fault}, 72'h1);
      chk("end_halted", {71'h0, halted}, 72'h1);
      chk("end_valid", {71'h0, instr_valid}, 72'h0);
      chk("end_addr", address, 72'd8184);
      step();
      chk("end_valid_after", {71'h0, instr_valid}, 72'h0);
      chk("end_fpc_after", fetch_pc, 72'd8184);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
